// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, serializer-driven data,
// optional parity and stop bits around an external 8-bit serializer.
module uart_tx_ctrl (
    input  logic       clk_ctl,
    input  logic       rst_ctl,
    input  logic [7:0] p_data_ctl,
    input  logic       data_valid_ctl,
    input  logic       par_en_ctl,
    input  logic       par_typ_ctl,
    input  logic       ser_done_ctl,
    input  logic       ser_data_ctl,
    output logic       ser_en_ctl,
    output logic [7:0] p_data_ser_ctl,
    output logic       tx_out_ctl,
    output logic       busy_ctl,
    output logic       err_ctl
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Watchdog value seen in the last DATA cycle it tolerates (the 9th).
    localparam logic [3:0] WDOG_LAST = 4'd8;

    logic [2:0] state_q,   state_d;
    logic [7:0] data_q,    data_d;
    logic       par_en_q,  par_en_d;
    logic       par_bit_q, par_bit_d;
    logic [3:0] wdog_q,    wdog_d;
    logic       load_s;
    logic       err_s;

    // Even parity is the XOR of the byte; odd parity inverts it.
    function automatic logic parity_f(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Next-state, frame latching and watchdog logic.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        wdog_d    = 4'd0;
        load_s    = 1'b0;
        err_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_valid_ctl) begin
                    load_s  = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                wdog_d = wdog_q + 4'd1;
                if (ser_done_ctl) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else if (wdog_q == WDOG_LAST) begin
                    err_s   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                // Back-to-back frames: a byte offered during STOP starts at once.
                if (data_valid_ctl) begin
                    load_s  = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load_s) begin
            data_d    = p_data_ctl;
            par_en_d  = par_en_ctl;
            par_bit_d = parity_f(p_data_ctl, par_typ_ctl);
        end else begin
            data_d    = data_q;
        end
    end

    // State and latched-frame registers.
    always_ff @(posedge clk_ctl or negedge rst_ctl) begin
        if (!rst_ctl) begin
            state_q   <= S_IDLE;
            data_q    <= 8'h00;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            wdog_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            wdog_q    <= wdog_d;
        end
    end

    // Line level and status decoded from the state.
    always_comb begin
        tx_out_ctl = 1'b1;
        case (state_q)
            S_IDLE:   tx_out_ctl = 1'b1;
            S_START:  tx_out_ctl = 1'b0;
            S_DATA:   tx_out_ctl = ser_data_ctl;
            S_PARITY: tx_out_ctl = par_bit_q;
            S_STOP:   tx_out_ctl = 1'b1;
            default:  tx_out_ctl = 1'b1;
        endcase
    end

    assign ser_en_ctl     = (state_q == S_START) || (state_q == S_DATA);
    assign busy_ctl       = (state_q != S_IDLE);
    assign err_ctl        = err_s;
    assign p_data_ser_ctl = data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized scoreboard bench for uart_tx_ctrl with a behavioural serializer
// and a frame-level reference model.
module tb_uart_tx_ctrl;

    logic       clk_ctl = 1'b0;
    logic       rst_ctl = 1'b0;
    logic [7:0] p_data_ctl = 8'h00;
    logic       data_valid_ctl = 1'b0;
    logic       par_en_ctl = 1'b0;
    logic       par_typ_ctl = 1'b0;
    logic       ser_done_ctl;
    logic       ser_data_ctl;
    logic       ser_en_ctl;
    logic [7:0] p_data_ser_ctl;
    logic       tx_out_ctl;
    logic       busy_ctl;
    logic       err_ctl;

    uart_tx_ctrl dut (
        .clk_ctl        (clk_ctl),
        .rst_ctl        (rst_ctl),
        .p_data_ctl     (p_data_ctl),
        .data_valid_ctl (data_valid_ctl),
        .par_en_ctl     (par_en_ctl),
        .par_typ_ctl    (par_typ_ctl),
        .ser_done_ctl   (ser_done_ctl),
        .ser_data_ctl   (ser_data_ctl),
        .ser_en_ctl     (ser_en_ctl),
        .p_data_ser_ctl (p_data_ser_ctl),
        .tx_out_ctl     (tx_out_ctl),
        .busy_ctl       (busy_ctl),
        .err_ctl        (err_ctl)
    );

    always #5 clk_ctl = ~clk_ctl;

    // Serializer: counts enabled cycles (saturating at 8), emits bit cnt-1.
    logic [3:0] ser_cnt;
    bit         stuck = 1'b0;
    always @(posedge clk_ctl or negedge rst_ctl) begin
        if (!rst_ctl)        ser_cnt <= 4'd0;
        else if (ser_en_ctl) ser_cnt <= (ser_cnt >= 4'd8) ? 4'd8 : ser_cnt + 4'd1;
        else                 ser_cnt <= 4'd0;
    end
    assign ser_done_ctl = !stuck && (ser_cnt == 4'd8);
    assign ser_data_ctl = (ser_cnt == 4'd0) ? 1'b0 : p_data_ser_ctl[3'(ser_cnt - 4'd1)];

    typedef struct {
        int         len;
        logic [10:0] bits;
        int         err_at;
        bit         b2b;
        logic [7:0] data;
    } frame_t;

    frame_t sbq[$];
    int     n_pass = 0;
    int     n_total = 0;

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    // Expected line sequence of one frame, from the frame format rules.
    function automatic frame_t model(input logic [7:0] d, input logic pe, input logic pt,
                                     input bit b2b, input bit stall);
        frame_t f;
        int     ones;
        f.data = d;
        f.b2b  = b2b;
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) f.bits[k+1] = d[k];
        if (stall) begin
            f.len    = 10;
            f.err_at = 9;
            f.bits[9] = d[7];
        end else begin
            ones     = $countones(d);
            f.err_at = -1;
            f.len    = pe ? 11 : 10;
            if (pe) f.bits[9] = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
            f.bits[f.len-1] = 1'b1;
        end
        return f;
    endfunction

    // Monitor: pops an expected frame whenever the DUT starts one.
    bit          in_frame = 1'b0;
    bit          must_start = 1'b0;
    int          idx = 0;
    frame_t      cur;
    logic [11:0] exp_v;
    always @(negedge clk_ctl) begin
        if (!rst_ctl) begin
            in_frame   = 1'b0;
            must_start = 1'b0;
            sbq.delete();
        end else begin
            if (!in_frame) begin
                if (must_start) chk("b2b_start", {15'd0, busy_ctl}, 16'd1);
                must_start = 1'b0;
                if (busy_ctl) begin
                    if (sbq.size() == 0) chk("spurious_frame", {15'd0, busy_ctl}, 16'd0);
                    else begin
                        cur      = sbq.pop_front();
                        in_frame = 1'b1;
                        idx      = 0;
                    end
                end else begin
                    chk("idle", {12'd0, tx_out_ctl, busy_ctl, ser_en_ctl, err_ctl}, 16'b1000);
                end
            end
            if (in_frame) begin
                exp_v = {cur.bits[idx], 1'b1, (idx < ((cur.err_at >= 0) ? 10 : 9)),
                         (idx == cur.err_at), cur.data};
                chk($sformatf("frame_bit%0d", idx),
                    {4'd0, tx_out_ctl, busy_ctl, ser_en_ctl, err_ctl, p_data_ser_ctl},
                    {4'd0, exp_v});
                idx++;
                if (idx == cur.len) begin
                    in_frame   = 1'b0;
                    must_start = (sbq.size() > 0) && sbq[0].b2b;
                end
            end
        end
    end

    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input bit spur, input bit stall, input int gap);
        frame_t f;
        @(negedge clk_ctl);
        stuck = stall;
        p_data_ctl = d; par_en_ctl = pe; par_typ_ctl = pt; data_valid_ctl = 1'b1;
        f = model(d, pe, pt, 1'b0, stall);
        sbq.push_back(f);
        @(posedge clk_ctl);
        for (int c = 0; c < f.len; c++) begin
            @(negedge clk_ctl);
            data_valid_ctl = spur && (c == 4);
            if (spur && (c == 4)) begin
                p_data_ctl  = 8'hFF;
                par_en_ctl  = 1'($urandom);
                par_typ_ctl = 1'($urandom);
            end
        end
        @(posedge clk_ctl);
        @(negedge clk_ctl);
        stuck = 1'b0;
        repeat (gap) @(negedge clk_ctl);
    endtask

    task automatic run_pair(input logic [7:0] d1, input logic pe1, input logic pt1,
                            input logic [7:0] d2, input logic pe2, input logic pt2);
        frame_t fa, fb;
        @(negedge clk_ctl);
        p_data_ctl = d1; par_en_ctl = pe1; par_typ_ctl = pt1; data_valid_ctl = 1'b1;
        fa = model(d1, pe1, pt1, 1'b0, 1'b0);
        sbq.push_back(fa);
        @(posedge clk_ctl);
        for (int c = 0; c < fa.len; c++) begin
            @(negedge clk_ctl);
            if (c == 0) begin
                p_data_ctl = d2; par_en_ctl = pe2; par_typ_ctl = pt2;
                fb = model(d2, pe2, pt2, 1'b1, 1'b0);
                sbq.push_back(fb);
            end
        end
        @(posedge clk_ctl);
        for (int c = 0; c < fb.len; c++) begin
            @(negedge clk_ctl);
            data_valid_ctl = 1'b0;
        end
        @(posedge clk_ctl);
        @(negedge clk_ctl);
    endtask

    task automatic run_reset_abort();
        @(negedge clk_ctl);
        p_data_ctl = 8'($urandom); par_en_ctl = 1'($urandom); par_typ_ctl = 1'($urandom);
        data_valid_ctl = 1'b1;
        sbq.push_back(model(p_data_ctl, par_en_ctl, par_typ_ctl, 1'b0, 1'b0));
        @(posedge clk_ctl);
        // Cycle 5 after START is data bit 4.
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk_ctl);
            data_valid_ctl = 1'b0;
        end
        #1 rst_ctl = 1'b0;
        #1 chk("reset_abort", {3'd0, tx_out_ctl, busy_ctl, ser_en_ctl, err_ctl, p_data_ser_ctl},
               {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        repeat (2) @(negedge clk_ctl);
        rst_ctl = 1'b1;
        run_frame(8'h5A, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1);
    endtask

    initial begin
        int kind;
        repeat (3) @(negedge clk_ctl);
        chk("reset_state", {4'd0, tx_out_ctl, busy_ctl, ser_en_ctl, err_ctl, p_data_ser_ctl},
            {4'd0, 4'b1000, 8'h00});
        rst_ctl = 1'b1;

        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        run_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_pair(8'h3C, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        run_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        run_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        run_reset_abort();

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 5)
                run_frame(8'($urandom), 1'($urandom), 1'($urandom), kind == 5, 1'b0,
                          int'($urandom_range(0, 3)));
            else if (kind <= 7)
                run_pair(8'($urandom), 1'($urandom), 1'($urandom),
                         8'($urandom), 1'($urandom), 1'($urandom));
            else if (kind == 8)
                run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1, 1);
            else
                run_reset_abort();
        end

        repeat (20) @(negedge clk_ctl);
        chk("drain", {15'd0, in_frame} | 16'(sbq.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have one clock, clk_ctl (input, 1 bit), rising-edge active; one clock cycle equals one bit time.
REQ-002 The block SHALL have one reset, rst_ctl (input, 1 bit); reset is asynchronous and active-low.
REQ-003 p_data_ctl  input  8  parallel byte to transmit.
REQ-004 data_valid_ctl  input  1  byte-offer strobe, sampled on clk_ctl.
REQ-005 par_en_ctl  input  1  1 = insert a parity bit.
REQ-006 par_typ_ctl  input  1  0 = even parity, 1 = odd parity.
REQ-007 ser_done_ctl  input  1  serializer done flag; high while the serializer count equals 8.
REQ-008 ser_data_ctl  input  1  serializer bit output.
REQ-009 ser_en_ctl  output  1  serializer enable.
REQ-010 p_data_ser_ctl  output  8  latched byte driven to the serializer parallel input.
REQ-011 tx_out_ctl  output  1  UART line; idle level is 1.
REQ-012 busy_ctl  output  1  high while a frame is in progress.
REQ-013 err_ctl  output  1  one-cycle pulse on a serializer timeout.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP, held in a registered state variable.
REQ-015 IDLE: tx_out_ctl=1, busy_ctl=0, ser_en_ctl=0; when data_valid_ctl=1, the block SHALL latch p_data_ctl, par_en_ctl and par_typ_ctl, compute parity, and go to START on that edge.
REQ-016 Parity SHALL be computed from the latched byte: even parity = XOR of the 8 bits; odd parity = inverse of that XOR.
REQ-017 START SHALL last 1 cycle with tx_out_ctl=0, then go to DATA.
REQ-018 ser_en_ctl SHALL equal 1 exactly when the state is START or DATA; it SHALL be decoded combinationally from the state.
REQ-019 DATA: tx_out_ctl=ser_data_ctl; bits leave LSB first, one per cycle, for 8 cycles.
REQ-020 In DATA, when ser_done_ctl=1, the FSM SHALL go to PARITY if the latched parity enable is 1, otherwise to STOP.
REQ-021 PARITY SHALL last 1 cycle with tx_out_ctl equal to the latched parity bit, then go to STOP.
REQ-022 STOP SHALL last 1 cycle with tx_out_ctl=1.
REQ-023 On leaving STOP, the FSM SHALL go to START if data_valid_ctl=1 in that cycle (latching the new byte, back-to-back, no idle gap), otherwise to IDLE.
REQ-024 busy_ctl SHALL be 1 in START, DATA, PARITY and STOP.
REQ-025 data_valid_ctl SHALL be ignored in START, DATA and PARITY; the latched byte and configuration SHALL stay stable for the whole frame.
REQ-026 Frame length SHALL be 11 cycles with parity and 10 cycles without, counted from the START cycle to the STOP cycle inclusive.
REQ-027 A 4-bit watchdog SHALL count cycles spent in DATA.
REQ-028 If the watchdog reaches 9 while ser_done_ctl=0, the FSM SHALL pulse err_ctl for 1 cycle and go to IDLE.
REQ-029 Both tx_out_ctl and busy_ctl SHALL be decoded combinationally from the state.
REQ-030 p_data_ser_ctl SHALL be driven directly from the latched byte register.

Reset
REQ-031 While rst_ctl=0: state=IDLE, tx_out_ctl=1, busy_ctl=0, ser_en_ctl=0, err_ctl=0, p_data_ser_ctl=8'h00, latched parity bit=0, latched configuration=0, watchdog=0.
REQ-032 A reset asserted mid-frame SHALL abort the frame immediately (asynchronously).
REQ-033 After a mid-frame reset, the line SHALL read 1 with no partial stop bit.
REQ-034 After reset is released, the first edge with data_valid_ctl=1 SHALL start a new frame.

Verification
REQ-035 Send 0xA5, par_en=1, par_typ=0 -> tx_out_ctl = 0,1,0,1,0,0,1,0,1,0,1 across 11 cycles; busy_ctl high for those 11 cycles.
REQ-036 Send 0xA5, par_en=1, par_typ=1 -> parity bit = 1; send 0x00, par_en=0 -> 10-cycle frame 0,0,0,0,0,0,0,0,0,1.
REQ-037 Hold data_valid_ctl high with 0x3C followed by 0xC3 -> the second START immediately follows the first STOP; no IDLE cycle appears between frames.
REQ-038 Pulse data_valid_ctl with 0xFF during DATA -> pulse ignored; the frame in progress is unchanged; no second frame starts.
REQ-039 Force ser_done_ctl=0 (serializer stuck) -> err_ctl pulses once on the 9th DATA cycle; the next state is IDLE with tx_out_ctl=1.
REQ-040 Assert rst_ctl=0 during data bit 4 -> tx_out_ctl=1, busy_ctl=0 and ser_en_ctl=0 immediately; after release, 0x5A transmits correctly.
